// File: rtl/mem.sv
// Memory-access stage of the 5-stage RV32I pipeline.
// Issues load/store requests to data memory over a req/ready handshake,
// builds byte enables and lane-replicated store data, extracts and
// sign/zero-extends load data, and holds the MEM/WB pipeline register.
// The pipeline is stalled while data memory has not accepted/completed.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses issue no request and
//               retire as a trap (o_trap=1, o_vld=1, o_rd_wen=0).
//   undefined - o_trap is tied low and address bits below the access
//               size are simply ignored.
module mem #(
  parameter logic [31:0] RST_INST = 32'h00000033
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [2:0]  i_opsel,
  input  logic [31:0] i_res,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  output logic        o_stall,
  output logic        o_vld,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_trap
);

  // IDLE: no access outstanding. WAIT: a request is pending on memory.
  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e state_q, state_d;

  logic        isLoad;
  logic        sizeByte;
  logic        sizeHalf;
  logic        sizeWord;
  logic        misaligned;
  logic        memOp;
  logic        stall;
  logic        dmemReq;
  logic [1:0]  byteOff;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;

  // MEM/WB pipeline register
  logic        vld_q, vld_d;
  logic        rdWen_q, rdWen_d;
  logic [4:0]  rdWaddr_q, rdWaddr_d;
  logic [31:0] rdWdata_q, rdWdata_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] nxtPc_q, nxtPc_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`endif

  assign byteOff = i_res[1:0];
  assign isLoad  = i_mem_read & ~i_mem_write;

  // Decode access width from funct3; unsigned widths only exist for loads,
  // so a store with funct3 100/101 decodes to no width (mask stays zero).
  always_comb begin
    sizeByte = 1'b0;
    sizeHalf = 1'b0;
    sizeWord = 1'b0;
    case (i_opsel)
      3'b000:  sizeByte = 1'b1;
      3'b001:  sizeHalf = 1'b1;
      3'b010:  sizeWord = 1'b1;
      3'b100:  sizeByte = isLoad;
      3'b101:  sizeHalf = isLoad;
      default: ;
    endcase
  end

  // Byte enables and lane-replicated store data; halfwords use only a[1],
  // so an odd halfword address behaves like the aligned one below it.
  always_comb begin
    mask  = 4'b0000;
    wdata = 32'h0000_0000;
    if (sizeByte) begin
      mask  = 4'b0001 << byteOff;
      wdata = {4{i_rs2_rdata[7:0]}};
    end else if (sizeHalf) begin
      mask  = 4'b0011 << {byteOff[1], 1'b0};
      wdata = {2{i_rs2_rdata[15:0]}};
    end else if (sizeWord) begin
      mask  = 4'b1111;
      wdata = i_rs2_rdata;
    end
  end

  // Pick the addressed byte/halfword lane out of the returned word.
  always_comb begin
    byteLane = i_dmem_rdata[7:0];
    case (byteOff)
      2'd0: byteLane = i_dmem_rdata[7:0];
      2'd1: byteLane = i_dmem_rdata[15:8];
      2'd2: byteLane = i_dmem_rdata[23:16];
      2'd3: byteLane = i_dmem_rdata[31:24];
      default: ;
    endcase
    halfLane = byteOff[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  end

  // Sign/zero-extend the selected lane; funct3[2] marks the unsigned loads.
  always_comb begin
    loadData = 32'h0000_0000;
    if (sizeByte) begin
      loadData = i_opsel[2] ? {24'h000000, byteLane}
                            : {{24{byteLane[7]}}, byteLane};
    end else if (sizeHalf) begin
      loadData = i_opsel[2] ? {16'h0000, halfLane}
                            : {{16{halfLane[15]}}, halfLane};
    end else if (sizeWord) begin
      loadData = i_dmem_rdata;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = i_vld & (i_mem_read | i_mem_write) &
                      ((sizeHalf & byteOff[0]) | (sizeWord & (byteOff != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // A trapping access never reaches memory, so it never stalls either.
  assign memOp = i_vld & (i_mem_read | i_mem_write) & ~misaligned;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake FSM: request while an access is presented, stall until ready.
  always_comb begin
    state_d = state_q;
    dmemReq = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmemReq = memOp;
        if (memOp && !i_dmem_ready) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dmemReq = memOp;
        stall   = memOp & ~i_dmem_ready;
        if (i_dmem_ready || !memOp) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB next state: a stall inserts a bubble and holds the payload,
  // otherwise the current EX/MEM entry is captured.
  always_comb begin
    vld_d     = vld_q;
    rdWen_d   = rdWen_q;
    rdWaddr_d = rdWaddr_q;
    rdWdata_d = rdWdata_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    nxtPc_d   = nxtPc_q;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    if (stall) begin
      vld_d   = 1'b0;
      rdWen_d = 1'b0;
    end else begin
      vld_d     = i_vld;
      rdWen_d   = i_vld & i_rd_wen & ~misaligned;
      rdWaddr_d = i_rd_waddr;
      rdWdata_d = i_mem_reg ? loadData : i_res;
      inst_d    = i_inst;
      pc_d      = i_pc;
      nxtPc_d   = i_nxt_pc;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_d    = misaligned;
`endif
    end
  end

  // MEM/WB register with synchronous reset to a retired nop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q     <= 1'b0;
      rdWen_q   <= 1'b0;
      rdWaddr_q <= 5'd0;
      rdWdata_q <= 32'h0000_0000;
      inst_q    <= RST_INST;
      pc_q      <= 32'h0000_0000;
      nxtPc_q   <= 32'h0000_0000;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      vld_q     <= vld_d;
      rdWen_q   <= rdWen_d;
      rdWaddr_q <= rdWaddr_d;
      rdWdata_q <= rdWdata_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      nxtPc_q   <= nxtPc_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign o_dmem_req   = dmemReq;
  assign o_dmem_wen   = i_mem_write;
  assign o_dmem_addr  = {i_res[31:2], 2'b00};
  assign o_dmem_mask  = mask;
  assign o_dmem_wdata = wdata;
  assign o_stall      = stall;

  assign o_vld      = vld_q;
  assign o_rd_wen   = rdWen_q;
  assign o_rd_waddr = rdWaddr_q;
  assign o_rd_wdata = rdWdata_q;
  assign o_inst     = inst_q;
  assign o_pc       = pc_q;
  assign o_nxt_pc   = nxtPc_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign o_trap     = trap_q;
`else
  assign o_trap     = 1'b0;
`endif

endmodule

// File: tb/tb_mem.sv
// Directed bench for the MEM stage: reset, ALU passthrough, stores,
// zero-wait loads, wait-state loads, reset mid-stall, misalignment.
module tb_mem;

  logic        i_clk;
  logic        i_rst;
  logic        i_vld;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_mem_reg;
  logic [2:0]  i_opsel;
  logic [31:0] i_res;
  logic [31:0] i_rs2_rdata;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_nxt_pc;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic        o_dmem_req;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        o_stall;
  logic        o_vld;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_nxt_pc;
  logic        o_trap;

  int checks = 0;
  int passes = 0;

  mem #(.RST_INST(32'h00000033)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_reg(i_mem_reg),
    .i_opsel(i_opsel), .i_res(i_res), .i_rs2_rdata(i_rs2_rdata),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst),
    .i_pc(i_pc), .i_nxt_pc(i_nxt_pc), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata), .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen),
    .o_dmem_addr(o_dmem_addr), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .o_stall(o_stall), .o_vld(o_vld), .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr),
    .o_rd_wdata(o_rd_wdata), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_trap(o_trap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive_idle;
    i_vld = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_reg = 1'b0;
    i_opsel = 3'b000; i_res = 32'h0; i_rs2_rdata = 32'h0; i_rd_waddr = 5'd0;
    i_rd_wen = 1'b0; i_inst = 32'h0; i_pc = 32'h0; i_nxt_pc = 32'h0;
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h0;
  endtask

  task automatic test_reset;
    drive_idle();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_vld !== 1'b0) $display("[TB] FAIL rst_vld got %b exp 0", o_vld); else passes++;
    checks++; if (o_rd_wen !== 1'b0) $display("[TB] FAIL rst_rd_wen got %b exp 0", o_rd_wen); else passes++;
    checks++; if (o_inst !== 32'h00000033) $display("[TB] FAIL rst_inst got %h exp 00000033", o_inst); else passes++;
    checks++; if (o_trap !== 1'b0) $display("[TB] FAIL rst_trap got %b exp 0", o_trap); else passes++;
    checks++; if (o_dmem_req !== 1'b0) $display("[TB] FAIL rst_req got %b exp 0", o_dmem_req); else passes++;
    checks++; if (o_rd_wdata !== 32'h0) $display("[TB] FAIL rst_wdata got %h exp 0", o_rd_wdata); else passes++;
    checks++; if (o_pc !== 32'h0) $display("[TB] FAIL rst_pc got %h exp 0", o_pc); else passes++;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_alu;
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_res = 32'h1234; i_rd_waddr = 5'd5; i_rd_wen = 1'b1;
    i_inst = 32'h00500293; i_pc = 32'h40; i_nxt_pc = 32'h44;
    #1;
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL alu_stall got %b exp 0", o_stall); else passes++;
    checks++; if (o_dmem_req !== 1'b0) $display("[TB] FAIL alu_req got %b exp 0", o_dmem_req); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_rd_wdata !== 32'h1234) $display("[TB] FAIL alu_wdata got %h exp 00001234", o_rd_wdata); else passes++;
    checks++; if (o_rd_waddr !== 5'd5) $display("[TB] FAIL alu_waddr got %0d exp 5", o_rd_waddr); else passes++;
    checks++; if (o_rd_wen !== 1'b1) $display("[TB] FAIL alu_rd_wen got %b exp 1", o_rd_wen); else passes++;
    checks++; if (o_vld !== 1'b1) $display("[TB] FAIL alu_vld got %b exp 1", o_vld); else passes++;
    checks++; if (o_inst !== 32'h00500293) $display("[TB] FAIL alu_inst got %h exp 00500293", o_inst); else passes++;
    checks++; if (o_pc !== 32'h40 || o_nxt_pc !== 32'h44) $display("[TB] FAIL alu_pc got %h/%h exp 40/44", o_pc, o_nxt_pc); else passes++;
    // back-to-back second op without write enable
    @(negedge i_clk);
    i_res = 32'hABCD; i_rd_waddr = 5'd6; i_rd_wen = 1'b0; i_pc = 32'h44; i_nxt_pc = 32'h48;
    #1;
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL alu2_stall got %b exp 0", o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_rd_wdata !== 32'hABCD) $display("[TB] FAIL alu2_wdata got %h exp 0000abcd", o_rd_wdata); else passes++;
    checks++; if (o_rd_wen !== 1'b0) $display("[TB] FAIL alu2_rd_wen got %b exp 0", o_rd_wen); else passes++;
    checks++; if (o_pc !== 32'h44) $display("[TB] FAIL alu2_pc got %h exp 44", o_pc); else passes++;
    // invalid entry carrying a load: no request, bubble registered
    @(negedge i_clk);
    i_vld = 1'b0; i_mem_read = 1'b1; i_rd_wen = 1'b1; i_dmem_ready = 1'b0;
    #1;
    checks++; if (o_dmem_req !== 1'b0) $display("[TB] FAIL inv_req got %b exp 0", o_dmem_req); else passes++;
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL inv_stall got %b exp 0", o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_vld !== 1'b0 || o_rd_wen !== 1'b0) $display("[TB] FAIL inv_vld got %b/%b exp 0/0", o_vld, o_rd_wen); else passes++;
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] res, input logic [31:0] rs2,
                           input logic [3:0] expMask, input logic [31:0] expWdata, input bit chkData);
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_mem_write = 1'b1; i_opsel = f3; i_res = res; i_rs2_rdata = rs2;
    i_dmem_ready = 1'b1;
    #1;
    checks++; if (o_dmem_req !== 1'b1 || o_dmem_wen !== 1'b1) $display("[TB] FAIL st_req f3=%b got %b/%b exp 1/1", f3, o_dmem_req, o_dmem_wen); else passes++;
    checks++; if (o_dmem_addr !== {res[31:2], 2'b00}) $display("[TB] FAIL st_addr f3=%b got %h exp %h", f3, o_dmem_addr, {res[31:2], 2'b00}); else passes++;
    checks++; if (o_dmem_mask !== expMask) $display("[TB] FAIL st_mask f3=%b got %b exp %b", f3, o_dmem_mask, expMask); else passes++;
    if (chkData) begin
      checks++; if (o_dmem_wdata !== expWdata) $display("[TB] FAIL st_wdata f3=%b got %h exp %h", f3, o_dmem_wdata, expWdata); else passes++;
    end
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL st_stall f3=%b got %b exp 0", f3, o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_vld !== 1'b1 || o_rd_wen !== 1'b0) $display("[TB] FAIL st_retire f3=%b got %b/%b exp 1/0", f3, o_vld, o_rd_wen); else passes++;
  endtask

  task automatic test_store;
    run_store(3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 1'b1);
    run_store(3'b000, 32'h101, 32'h1234565A, 4'b0010, 32'h5A5A5A5A, 1'b1);
    run_store(3'b001, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 1'b1);
    run_store(3'b001, 32'h100, 32'h12345678, 4'b0011, 32'h56785678, 1'b1);
    run_store(3'b010, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b1);
    run_store(3'b011, 32'h104, 32'h11223344, 4'b0000, 32'h0, 1'b0);
    run_store(3'b100, 32'h104, 32'h11223344, 4'b0000, 32'h0, 1'b0);
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] res, input logic [31:0] rdata,
                          input logic [3:0] expMask, input logic [31:0] expData);
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_reg = 1'b1; i_opsel = f3; i_res = res;
    i_rd_waddr = 5'd10; i_rd_wen = 1'b1; i_dmem_ready = 1'b1; i_dmem_rdata = rdata;
    #1;
    checks++; if (o_dmem_req !== 1'b1 || o_dmem_wen !== 1'b0) $display("[TB] FAIL ld_req f3=%b got %b/%b exp 1/0", f3, o_dmem_req, o_dmem_wen); else passes++;
    checks++; if (o_dmem_mask !== expMask) $display("[TB] FAIL ld_mask f3=%b got %b exp %b", f3, o_dmem_mask, expMask); else passes++;
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL ld_stall f3=%b got %b exp 0", f3, o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_rd_wdata !== expData) $display("[TB] FAIL ld_data f3=%b got %h exp %h", f3, o_rd_wdata, expData); else passes++;
    checks++; if (o_vld !== 1'b1 || o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd10) $display("[TB] FAIL ld_retire f3=%b got %b/%b/%0d exp 1/1/10", f3, o_vld, o_rd_wen, o_rd_waddr); else passes++;
  endtask

  task automatic test_load;
    run_load(3'b010, 32'h200, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE);
    run_load(3'b001, 32'h200, 32'h12348001, 4'b0011, 32'hFFFF8001);
    run_load(3'b001, 32'h202, 32'h7FFF0000, 4'b1100, 32'h00007FFF);
    run_load(3'b101, 32'h202, 32'hF00D1234, 4'b1100, 32'h0000F00D);
    run_load(3'b000, 32'h201, 32'h0000FE00, 4'b0010, 32'hFFFFFFFE);
    run_load(3'b100, 32'h203, 32'hFF000000, 4'b1000, 32'h000000FF);
    run_load(3'b011, 32'h200, 32'hFFFFFFFF, 4'b0000, 32'h00000000);
  endtask

  task automatic test_load_wait(input logic [2:0] f3, input logic [31:0] expData, input string name);
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_reg = 1'b1; i_opsel = f3; i_res = 32'h102;
    i_rd_waddr = 5'd7; i_rd_wen = 1'b1; i_pc = 32'h80; i_nxt_pc = 32'h84;
    i_dmem_ready = 1'b0; i_dmem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge i_clk);
      #1;
      checks++; if (o_stall !== 1'b1) $display("[TB] FAIL %s_stall%0d got %b exp 1", name, i, o_stall); else passes++;
      checks++; if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_mask !== 4'b0100) $display("[TB] FAIL %s_req%0d got %b/%h/%b exp 1/00000100/0100", name, i, o_dmem_req, o_dmem_addr, o_dmem_mask); else passes++;
      @(posedge i_clk); #1;
      checks++; if (o_vld !== 1'b0 || o_rd_wen !== 1'b0) $display("[TB] FAIL %s_bubble%0d got %b/%b exp 0/0", name, i, o_vld, o_rd_wen); else passes++;
    end
    @(negedge i_clk);
    i_dmem_ready = 1'b1; i_dmem_rdata = 32'h00800000;
    #1;
    checks++; if (o_stall !== 1'b0) $display("[TB] FAIL %s_stall_end got %b exp 0", name, o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_rd_wdata !== expData) $display("[TB] FAIL %s_data got %h exp %h", name, o_rd_wdata, expData); else passes++;
    checks++; if (o_vld !== 1'b1 || o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd7 || o_pc !== 32'h80) $display("[TB] FAIL %s_retire got %b/%b/%0d/%h exp 1/1/7/80", name, o_vld, o_rd_wen, o_rd_waddr, o_pc); else passes++;
    @(negedge i_clk);
    drive_idle();
    #1;
    checks++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) $display("[TB] FAIL %s_idle got %b/%b exp 0/0", name, o_stall, o_dmem_req); else passes++;
  endtask

  task automatic test_reset_wait;
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_reg = 1'b1; i_opsel = 3'b010; i_res = 32'h200;
    i_rd_waddr = 5'd9; i_rd_wen = 1'b1; i_inst = 32'h12345678; i_dmem_ready = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b1) $display("[TB] FAIL rw_stall got %b exp 1", o_stall); else passes++;
    @(posedge i_clk);
    @(negedge i_clk);
    // reset lands while memory finally answers: the access must be discarded
    i_rst = 1'b1; i_dmem_ready = 1'b1; i_dmem_rdata = 32'h55555555;
    @(posedge i_clk); #1;
    checks++; if (o_vld !== 1'b0 || o_rd_wen !== 1'b0) $display("[TB] FAIL rw_vld got %b/%b exp 0/0", o_vld, o_rd_wen); else passes++;
    checks++; if (o_rd_wdata !== 32'h0 || o_inst !== 32'h00000033) $display("[TB] FAIL rw_regs got %h/%h exp 0/00000033", o_rd_wdata, o_inst); else passes++;
    drive_idle();
    #1;
    checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) $display("[TB] FAIL rw_req got %b/%b exp 0/0", o_dmem_req, o_stall); else passes++;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (o_vld !== 1'b0 || o_rd_waddr !== 5'd0) $display("[TB] FAIL rw_nowb got %b/%0d exp 0/0", o_vld, o_rd_waddr); else passes++;
  endtask

  task automatic test_misalign;
    @(negedge i_clk);
    drive_idle();
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_reg = 1'b1; i_opsel = 3'b010; i_res = 32'h102;
    i_rd_waddr = 5'd3; i_rd_wen = 1'b1; i_dmem_ready = 1'b0; i_dmem_rdata = 32'h0BADF00D;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) $display("[TB] FAIL mis_req got %b/%b exp 0/0", o_dmem_req, o_stall); else passes++;
    @(posedge i_clk); #1;
    checks++; if (o_trap !== 1'b1 || o_vld !== 1'b1 || o_rd_wen !== 1'b0) $display("[TB] FAIL mis_trap got %b/%b/%b exp 1/1/0", o_trap, o_vld, o_rd_wen); else passes++;
`else
    #1;
    checks++; if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_mask !== 4'hF) $display("[TB] FAIL mis_req got %b/%h/%h exp 1/00000100/f", o_dmem_req, o_dmem_addr, o_dmem_mask); else passes++;
    @(negedge i_clk);
    i_dmem_ready = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_trap !== 1'b0 || o_vld !== 1'b1 || o_rd_wdata !== 32'h0BADF00D) $display("[TB] FAIL mis_retire got %b/%b/%h exp 0/1/0badf00d", o_trap, o_vld, o_rd_wdata); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_load_wait(3'b000, 32'hFFFFFF80, "lb_wait");
    test_load_wait(3'b100, 32'h00000080, "lbu_wait");
    test_reset_wait();
    test_misalign();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
